// File: rtl/bht_update_queue.sv
// bht_update_queue: FIFO of resolved conditional-branch outcomes feeding BHT training.
// Optional feature macro BHT_UPDATE_COALESCE_EN merges pushes hitting the youngest pc.
package config_pkg;
  typedef struct packed {
    int unsigned VLEN;
  } cva6_cfg_t;
  localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32'd0};
endpackage

package riscv;
  localparam int unsigned VLEN = 32;
endpackage

package ariane_pkg;
  typedef struct packed {
    logic                   valid;
    logic [riscv::VLEN-1:0] pc;
    logic                   taken;
  } bht_update_t;
endpackage

module bht_update_queue #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         debug_mode_i,
  input  logic                         resolve_valid_i,
  input  logic                         resolve_is_branch_i,
  input  logic [riscv::VLEN-1:0]       resolve_pc_i,
  input  logic                         resolve_taken_i,
  output logic                         resolve_ready_o,
  output ariane_pkg::bht_update_t      bht_update_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic [15:0]                  drop_count_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam logic [CntW-1:0] FULL = CntW'(DEPTH);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bht_update_queue: DEPTH must be a power of two >= 2");
  end
  if (CVA6Cfg.VLEN != 0 && CVA6Cfg.VLEN != riscv::VLEN) begin : g_bad_vlen
    $error("bht_update_queue: CVA6Cfg.VLEN disagrees with riscv::VLEN");
  end

  logic [0:0]             state_q, state_d;
  logic [riscv::VLEN-1:0] pc_q [DEPTH];
  logic [DEPTH-1:0]       taken_q;
  logic [PtrW-1:0]        wptr_q, rptr_q;
  logic [CntW-1:0]        count_q;
  logic [15:0]            drops_q;
  ariane_pkg::bht_update_t upd_q;

  logic push_req, pop, merge, alloc, drop;

  assign push_req = resolve_valid_i && resolve_is_branch_i
                    && !flush_i && (state_q == RUN);
  assign pop = (state_q == RUN) && !debug_mode_i
               && (count_q != '0) && !flush_i;
  assign resolve_ready_o = (count_q < FULL) || pop;

`ifdef BHT_UPDATE_COALESCE_EN
  logic [PtrW-1:0] last_ptr;
  assign last_ptr = wptr_q - PtrW'(1);
  // A hit on the youngest entry only rewrites its outcome, unless that
  // entry is the head and is leaving this very cycle.
  assign merge = push_req && (count_q != '0)
                 && (pc_q[last_ptr] == resolve_pc_i)
                 && !(pop && count_q == CntW'(1));
`else
  assign merge = 1'b0;
`endif

  assign alloc = push_req && !merge && resolve_ready_o;
  assign drop  = push_req && !merge && !resolve_ready_o;

  // Next debug-hold state: training pauses while the core is in debug mode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (debug_mode_i) state_d = HOLD;
      HOLD:    if (!debug_mode_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Entry storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      pc_q[wptr_q]    <= resolve_pc_i;
      taken_q[wptr_q] <= resolve_taken_i;
    end
`ifdef BHT_UPDATE_COALESCE_EN
    if (merge) taken_q[last_ptr] <= resolve_taken_i;
`endif
  end

  // Pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (alloc) wptr_q <= wptr_q + PtrW'(1);
      if (pop)   rptr_q <= rptr_q + PtrW'(1);
      if (alloc && !pop)      count_q <= count_q + CntW'(1);
      else if (!alloc && pop) count_q <= count_q - CntW'(1);
    end
  end

  // Registered update towards the BHT: one head entry per pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      upd_q <= '0;
    end else if (pop) begin
      upd_q.valid <= 1'b1;
      upd_q.pc    <= pc_q[rptr_q];
      upd_q.taken <= taken_q[rptr_q];
    end else begin
      upd_q.valid <= 1'b0;
    end
  end

  // Saturating count of pushes lost to a full queue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      drops_q <= '0;
    else if (drop && drops_q != '1) drops_q <= drops_q + 16'd1;
  end

  assign bht_update_o = upd_q;
  assign occupancy_o  = count_q;
  assign drop_count_o = drops_q;

endmodule

// File: tb/tb_bht_update_queue.sv
// tb_bht_update_queue: directed bench with a queue-level reference model.
// Same model logic covers BHT_UPDATE_COALESCE_EN when the macro is set.
module tb_bht_update_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        dbg = 1'b0;
  logic        rv = 1'b0;
  logic        rb = 1'b0;
  logic        rt = 1'b0;
  logic [31:0] rpc = '0;

  logic                    ready;
  ariane_pkg::bht_update_t upd;
  logic [2:0]              occ;
  logic [15:0]             drops;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bht_update_queue #(.DEPTH(DEPTH)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .flush_i             (flush),
    .debug_mode_i        (dbg),
    .resolve_valid_i     (rv),
    .resolve_is_branch_i (rb),
    .resolve_pc_i        (rpc),
    .resolve_taken_i     (rt),
    .resolve_ready_o     (ready),
    .bht_update_o        (upd),
    .occupancy_o         (occ),
    .drop_count_o        (drops)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of pending (pc, taken) pairs.
  typedef struct {
    logic [31:0] pc;
    logic        tk;
  } ent_t;

  ent_t        mq[$];
  bit          m_hold;
  bit          m_v;
  logic [31:0] m_pc;
  logic        m_tk;
  int          m_drops;

  always @(posedge clk or posedge rst) begin
    int n;
    bit mpop, mpush, ok, merged;
    if (rst) begin
      mq.delete();
      m_hold = 0; m_v = 0; m_pc = '0; m_tk = 0; m_drops = 0;
    end else begin
      n = mq.size();
      mpop  = !m_hold && !dbg && n != 0 && !flush;
      mpush = rv && rb && !flush && !m_hold;
      ok    = (n < DEPTH) || mpop;
      merged = 0;
      if (flush) begin
        mq.delete();
        m_v = 0;
      end else begin
        if (mpop) begin
          m_v = 1; m_pc = mq[0].pc; m_tk = mq[0].tk;
          void'(mq.pop_front());
        end else begin
          m_v = 0;
        end
        if (mpush) begin
`ifdef BHT_UPDATE_COALESCE_EN
          if (n != 0 && !(mpop && n == 1) && mq[mq.size()-1].pc == rpc) begin
            mq[mq.size()-1].tk = rt;
            merged = 1;
          end
`endif
          if (!merged) begin
            if (ok) mq.push_back('{rpc, rt});
            else if (m_drops < 65535) m_drops++;
          end
        end
      end
      m_hold = dbg;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit pnow;
    if (!rst) begin
      pnow = !m_hold && !dbg && mq.size() != 0 && !flush;
      chk("ready", 64'(ready), 64'((mq.size() < DEPTH) || pnow));
      chk("occupancy", 64'(occ), 64'(mq.size()));
      chk("drop_count", 64'(drops), 64'(m_drops));
      chk("upd_valid", 64'(upd.valid), 64'(m_v));
      if (m_v) chk("upd_pc_taken", {upd.pc, upd.taken}, {m_pc, m_tk});
    end
  end

  task automatic drive(input bit v, input bit b, input logic [31:0] pc,
                       input bit tk, input bit d, input bit f);
    @(posedge clk);
    #1;
    rv = v; rb = b; rpc = pc; rt = tk; dbg = d; flush = f;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, '0, 0, 0, 0);
  endtask

  // Queues n entries by alternating RUN/debug cycles; ends in debug.
  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      if (i > 0) drive(0, 0, '0, 0, 0, 0);
      drive(1, 1, base + 32'(4 * i), bit'(i & 1), 1, 0);
    end
  endtask

  task automatic count_valid(input int n, output int cnt, output logic lt);
    cnt = 0; lt = 1'bx;
    repeat (n) begin
      drive(0, 0, '0, 0, 0, 0);
      @(negedge clk);
      if (upd.valid) begin cnt++; lt = upd.taken; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    logic lt;
    bit   found;

    #12;
    chk("rst_occ", 64'(occ), 0);
    chk("rst_upd", 64'(upd), 0);
    chk("rst_drops", 64'(drops), 0);
    chk("rst_ready", 64'(ready), 1);
    @(posedge clk); #1 rst = 0;
    idle(2);

    // Single push: output exactly two cycles later, once.
    drive(1, 1, 32'h8000_0010, 1, 0, 0);
    @(negedge clk); chk("lat_c0_occ", 64'(occ), 0);
    idle(1);
    @(negedge clk); chk("lat_c1_valid", 64'(upd.valid), 0);
    idle(1);
    @(negedge clk);
    chk("lat_c2_upd", {upd.valid, upd.pc, upd.taken}, {1'b1, 32'h8000_0010, 1'b1});
    idle(1);
    @(negedge clk); chk("lat_c3_valid", 64'(upd.valid), 0);
    idle(2);

    // Debug hold with a full queue: resolves discarded, then FIFO drain.
    fill(4, 32'h1000);
    repeat (5) drive(1, 1, 32'h2000, 1, 1, 0);
    @(negedge clk);
    chk("hold_occ", 64'(occ), 4);
    chk("hold_drops", 64'(drops), 0);
    chk("hold_valid", 64'(upd.valid), 0);
    idle(1);
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      idle(1);
      @(negedge clk);
      if (upd.valid) found = 1;
    end
    chk("drain_start", 64'(found), 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin idle(1); @(negedge clk); end
      chk($sformatf("fifo_%0d", i), {upd.valid, upd.pc},
          {1'b1, 32'h1000 + 32'(4 * i)});
    end
    idle(2);

    // Full queue in RUN with pops blocked: three drops.
    fill(4, 32'h3000);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, '0, 0, 0, 0);
      drive(1, 1, 32'h3100 + 32'(i), 1, 1, 0);
      @(negedge clk);
      chk("full_ready", 64'(ready), 0);
    end
    idle(1);
    @(negedge clk); chk("drops3", 64'(drops), 3);
    drive(1, 1, 32'h3200, 1, 0, 0);
    @(negedge clk); chk("push_pop_ready", 64'(ready), 1);
    idle(1);
    @(negedge clk); chk("push_pop_occ", 64'(occ), 4);
    idle(8);

    // Flush with three queued and a same-cycle push.
    fill(3, 32'h4000);
    idle(1);
    drive(1, 1, 32'h4100, 1, 1, 1);
    idle(1);
    @(negedge clk);
    chk("flush_occ", 64'(occ), 0);
    chk("flush_valid", 64'(upd.valid), 0);
    count_valid(6, cnt, lt);
    chk("flush_no_emit", 64'(cnt), 0);

    // Same-pc back-to-back pushes while the output is held.
    idle(2);
    drive(1, 1, 32'h100, 0, 1, 0);
    drive(0, 0, '0, 0, 0, 0);
    drive(1, 1, 32'h100, 1, 1, 0);
    drive(0, 0, '0, 0, 1, 0);
    @(negedge clk);
`ifdef BHT_UPDATE_COALESCE_EN
    chk("same_pc_occ", 64'(occ), 1);
`else
    chk("same_pc_occ", 64'(occ), 2);
`endif
    count_valid(8, cnt, lt);
`ifdef BHT_UPDATE_COALESCE_EN
    chk("same_pc_count", 64'(cnt), 1);
`else
    chk("same_pc_count", 64'(cnt), 2);
`endif
    chk("same_pc_last_tk", 64'(lt), 1);

    // Asynchronous reset mid-cycle with two entries queued.
    idle(2);
    fill(2, 32'h5000);
    @(posedge clk);
    #1;
    rv = 0; rb = 0; dbg = 0; flush = 0;
    #1 rst = 1;
    #1;
    chk("arst_occ", 64'(occ), 0);
    chk("arst_upd", 64'(upd), 0);
    chk("arst_drops", 64'(drops), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    count_valid(6, cnt, lt);
    chk("arst_no_stale", 64'(cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
